// File: rtl/ashvin_viterbi.sv
// Hard-decision K=3 rate-1/2 (7,5) Viterbi decoder, 32-symbol frames, Tiny Tapeout pinout.
// Optional VITERBI_METRIC_OUT_EN drives the latched best path metric on uio_out.
module ashvin_viterbi (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {LOAD, TRACE, OUTPUT} state_t;

  localparam logic [3:0][6:0] PM_INIT = {7'd32, 7'd32, 7'd32, 7'd0};

  state_t          state, state_nx;
  logic [5:0]      count;
  logic [3:0][6:0] pm;
  logic [3:0][6:0] pm_acs, cand0, cand1;
  logic [3:0]      surv_bits;
  logic [3:0]      surv [32];
  logic [1:0]      tb_state, best_state;
  logic [6:0]      best_pm;
  logic [4:0]      t_idx, idx;
  logic [31:0]     decoded;
  logic            out_bit, frame_done, alive;
  logic            sym_valid, start, read_ack, rx_ready, accept, launch;
  logic [1:0]      sym;
  logic            unused;

  assign sym_valid = ui_in[0];
  assign sym       = ui_in[2:1];
  assign start     = ui_in[3];
  assign read_ack  = ui_in[4];
  assign unused    = ^{ena, uio_in, ui_in[7:5]};

  assign rx_ready = alive && (state == LOAD) && (count != 6'd32);
  assign accept   = sym_valid && rx_ready;
  assign launch   = (state == LOAD) && start && (count == 6'd32);

  function automatic logic [1:0] exp_sym(input logic [1:0] ns);
    return {ns[1] ^ ns[0], ns[0]};
  endfunction

  function automatic logic [6:0] hd(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] d;
    d = a ^ b;
    return 7'(d[0]) + 7'(d[1]);
  endfunction

  // The {1,a} predecessor emits the complement of the {0,a} branch symbol.
  always_comb begin
    cand0     = '0;
    cand1     = '0;
    pm_acs    = '0;
    surv_bits = '0;
    for (int unsigned n = 0; n < 4; n++) begin
      cand0[n[1:0]]     = pm[{1'b0, n[1]}] + hd(sym, exp_sym(n[1:0]));
      cand1[n[1:0]]     = pm[{1'b1, n[1]}] + hd(sym, ~exp_sym(n[1:0]));
      surv_bits[n[1:0]] = cand1[n[1:0]] < cand0[n[1:0]];
      pm_acs[n[1:0]]    = surv_bits[n[1:0]] ? cand1[n[1:0]] : cand0[n[1:0]];
    end
  end

  always_comb begin
    best_state = '0;
    best_pm    = pm[0];
    for (int unsigned i = 1; i < 4; i++) begin
      if (pm[i[1:0]] < best_pm) begin
        best_pm    = pm[i[1:0]];
        best_state = i[1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      LOAD:    if (launch) state_nx = TRACE;
      TRACE:   if (t_idx == 5'd0) state_nx = OUTPUT;
      OUTPUT:  if (read_ack && idx == 5'd31) state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) surv[count[4:0]] <= surv_bits;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      pm         <= PM_INIT;
      tb_state   <= '0;
      t_idx      <= '0;
      idx        <= '0;
      decoded    <= '0;
      out_bit    <= 1'b0;
      frame_done <= 1'b0;
      alive      <= 1'b0;
    end else begin
      alive <= 1'b1;
      case (state)
        LOAD: begin
          if (accept) begin
            pm         <= pm_acs;
            count      <= count + 6'd1;
            frame_done <= 1'b0;
          end
          if (launch) begin
            tb_state <= best_state;
            t_idx    <= 5'd31;
          end
        end
        TRACE: begin
          decoded[t_idx] <= tb_state[0];
          tb_state       <= {surv[t_idx][tb_state], tb_state[1]};
          t_idx          <= t_idx - 5'd1;
          // decoded[0] is being written this edge, so take it straight from the trace state.
          if (t_idx == 5'd0) begin
            idx     <= '0;
            out_bit <= tb_state[0];
          end
        end
        OUTPUT: begin
          if (read_ack) begin
            if (idx == 5'd31) begin
              frame_done <= 1'b1;
              out_bit    <= 1'b0;
              count      <= '0;
              pm         <= PM_INIT;
            end else begin
              idx     <= idx + 5'd1;
              out_bit <= decoded[idx + 5'd1];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign uo_out = {3'b000, frame_done, state == TRACE, out_bit, state == OUTPUT, rx_ready};

`ifdef VITERBI_METRIC_OUT_EN
  logic [6:0] metric_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      metric_q <= '0;
    else if (launch) metric_q <= best_pm;
  end

  assign uio_out = {1'b0, metric_q};
  assign uio_oe  = '1;
`else
  logic unused_metric;
  assign unused_metric = ^best_pm;
  assign uio_out = '0;
  assign uio_oe  = '0;
`endif

endmodule

// File: tb/tb_ashvin_viterbi.sv
// Directed bench for ashvin_viterbi: encodes frames, decodes them, checks outputs with immediate assertions.
module tb_ashvin_viterbi;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = '0;
  logic [7:0] uo_out;
  logic [7:0] uio_in = '0;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int total = 0;
  int bad   = 0;
  logic [1:0]  syms [32];
  logic [31:0] word;
  logic        all_valid;
  int          busy_cycles;

  ashvin_viterbi dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference (7,5) encoder from state 0; optionally flips sym[1] of one symbol.
  task automatic encode(input logic [31:0] w, input int flip);
    logic [1:0] s;
    logic       b;
    s = '0;
    for (int i = 0; i < 32; i++) begin
      b = w[i];
      syms[i] = {s[1] ^ s[0] ^ b, s[1] ^ b};
      if (i == flip) syms[i][1] = ~syms[i][1];
      s = {s[0], b};
    end
  endtask

  // All tasks are entered and left at a falling edge.
  task automatic feed(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      ui_in = {3'b000, 1'b1, 1'b0, syms[i], 1'b1};
      @(negedge clk);
    end
    ui_in = '0;
  endtask

  task automatic pulse_start();
    ui_in = 8'h08;
    @(negedge clk);
    ui_in = '0;
  endtask

  task automatic wait_trace();
    busy_cycles = 0;
    while (uo_out[3] && busy_cycles < 40) begin
      busy_cycles++;
      @(negedge clk);
    end
  endtask

  task automatic read_bits(input int n);
    all_valid = 1'b1;
    word = '0;
    for (int i = 0; i < n; i++) begin
      word[i]   = uo_out[2];
      all_valid = all_valid & uo_out[1];
      ui_in = 8'h10;
      @(negedge clk);
    end
    ui_in = '0;
  endtask

  task automatic decode_frame(input string tag, input logic [31:0] w, input int flip);
    encode(w, flip);
    feed(0, 31);
    chk({tag, "_full_rx_ready"}, 32'(uo_out), 32'h00);
    pulse_start();
    chk({tag, "_busy_rise"}, 32'(uo_out), 32'h08);
    wait_trace();
    chk({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd32);
    chk({tag, "_out_valid_rise"}, 32'(uo_out[3:0] & 4'b1011), 32'h2);
    read_bits(32);
    chk({tag, "_all_valid"}, 32'(all_valid), 32'd1);
    chk({tag, "_decoded"}, word, w);
    chk({tag, "_frame_done"}, 32'(uo_out), 32'h11);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_uo_out", 32'(uo_out), 32'h00);
    chk("reset_uio_out", 32'(uio_out), 32'h00);
`ifdef VITERBI_METRIC_OUT_EN
    chk("reset_uio_oe", 32'(uio_oe), 32'hFF);
`else
    chk("reset_uio_oe", 32'(uio_oe), 32'h00);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_rx_ready", 32'(uo_out), 32'h01);

    // Frame A: read_ack noise during load, one ignored symbol after the frame is full.
    encode(32'hB4B4B4B4, -1);
    feed(0, 31);
    chk("A_full_rx_ready", 32'(uo_out), 32'h00);
    ui_in = 8'h07;
    @(negedge clk);
    pulse_start();
    chk("A_busy_rise", 32'(uo_out), 32'h08);
    wait_trace();
    chk("A_busy_cycles", 32'(busy_cycles), 32'd32);
    chk("A_first_out", 32'(uo_out), 32'h02);
`ifdef VITERBI_METRIC_OUT_EN
    chk("A_metric", 32'(uio_out), 32'h00);
`endif
    read_bits(32);
    chk("A_all_valid", 32'(all_valid), 32'd1);
    chk("A_decoded", word, 32'hB4B4B4B4);
    chk("A_frame_done", 32'(uo_out), 32'h11);
    repeat (3) @(negedge clk);
    chk("A_frame_done_hold", 32'(uo_out), 32'h11);

    // Frame B back-to-back: frame_done must drop on the first accepted symbol.
    encode(32'h12345678, -1);
    feed(0, 0);
    chk("B_frame_done_clear", 32'(uo_out), 32'h01);
    feed(1, 31);
    pulse_start();
    wait_trace();
    chk("B_busy_cycles", 32'(busy_cycles), 32'd32);
    read_bits(32);
    chk("B_decoded", word, 32'h12345678);

    decode_frame("Z", 32'h00000000, -1);
    chk("Z_uio_out", 32'(uio_out), 32'h00);

    decode_frame("E", 32'hB4B4B4B4, 10);
`ifdef VITERBI_METRIC_OUT_EN
    chk("E_metric", 32'(uio_out), 32'h01);
`endif

    // Early start after 20 symbols is ignored.
    encode(32'h0F0F5A5A, -1);
    feed(0, 19);
    pulse_start();
    chk("early_start_ignored", 32'(uo_out), 32'h01);
    @(negedge clk);
    chk("early_start_idle", 32'(uo_out), 32'h01);
    feed(20, 31);
    pulse_start();
    wait_trace();
    chk("early_busy_cycles", 32'(busy_cycles), 32'd32);
    read_bits(32);
    chk("early_decoded", word, 32'h0F0F5A5A);

    // Reset while reading out.
    encode(32'hB4B4B4B4, -1);
    feed(0, 31);
    pulse_start();
    wait_trace();
    read_bits(10);
    chk("mid_partial", word & 32'h3FF, 32'h0B4);
    #2 rst_n = 1'b0;
    #1 chk("mid_reset_async", 32'(uo_out), 32'h00);
    @(negedge clk);
    chk("mid_reset_held", 32'(uo_out), 32'h00);
    chk("mid_reset_uio", 32'(uio_out), 32'h00);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_release_rx_ready", 32'(uo_out), 32'h01);
    decode_frame("R", 32'h9E3779B9, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ashvin_viterbi.md
# ashvin_viterbi

Hard-decision Viterbi decoder for the K=3, rate-1/2 convolutional code (G0=7, G1=5), wrapped in the standard Tiny Tapeout user-module pinout. The block does the following, in order:
- Accepts a frame of 32 two-bit code symbols over a one-symbol-per-cycle handshake, running add-compare-select per symbol.
- Performs a full-frame traceback on command.
- Returns the 32 decoded bits one at a time under a read-acknowledge handshake.

It is the top level of the tile.

## Interface
- No parameters. Frame length 32, constraint length 3, 4 states; all fixed.
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  ignored.
- ui_in  in  8  [0]=sym_valid, [2:1]=sym (bit1=G0 output, bit0=G1 output), [3]=start, [4]=read_ack, [7:5] ignored.
- uo_out  out  8  [0]=rx_ready, [1]=out_valid, [2]=out_bit, [3]=busy, [4]=frame_done, [7:5]=0.
- uio_in  in  8  ignored.
- uio_out  out  8  0 (see Configuration).
- uio_oe  out  8  0 (see Configuration).

## Operation
- Encoder model (what the bench encodes):
  - State s={s1,s0}, with s0 the newest bit.
  - For input b: sym[1]=s1^s0^b and sym[0]=s1^b.
  - Next state is {s0,b}, and the encoder starts in state 0.
- FSM states are LOAD, TRACE, OUTPUT.
- Reset: state=LOAD, symbol count=0, path metrics PM0=0 and PM1..3=32, all outputs 0.
- LOAD:
  - rx_ready=1 while count<32.
  - Each cycle with sym_valid=1 and rx_ready=1 runs one ACS step and increments count. sym_valid with rx_ready=0 is ignored.
- ACS step:
  - Branch metric = Hamming distance, range 0..2.
  - For next state {a,b}, the predecessors are {0,a} and {1,a}. Candidate = PM_pred + BM.
  - Keep the minimum; on a tie pick predecessor {0,a}.
  - Store the survivor bit (the MSB of the chosen predecessor) in survivor memory [step][state], 32x4 bits.
  - Metrics are 7-bit unsigned with no normalization (max 32+64=96).
- start, sampled in LOAD with count==32:
  - Select the final state with minimum PM, ties to the lowest index.
  - Enter TRACE with busy=1.
  - start at any other time is ignored.
- TRACE, one step per cycle from t=31 down to 0:
  - decoded[t] = s[0].
  - s becomes {surv[t][s], s[1]}.
  - After t=0, go to OUTPUT with busy=0, bit index=0.
- OUTPUT:
  - out_valid=1 and out_bit=decoded[index].
  - Each cycle with read_ack=1 advances index.
  - After index 31 is acknowledged, out_valid=0 and frame_done=1, then return to LOAD with count=0 and metrics re-initialized.
- frame_done stays high until the first symbol of the next frame is accepted.
- read_ack outside OUTPUT is ignored.
- The bit order out is the order the bits were encoded: the first bit out corresponds to the first symbol in.

## Timing
- rx_ready is high in the first cycle after rst_n deasserts.
- Symbols can be accepted on back-to-back cycles, with no wait states.
- busy rises on the edge that samples start and stays high for 32 cycles.
- out_valid rises on the same edge on which busy falls.
- out_bit is registered and stable while out_valid=1. It updates on the edge after an accepted read_ack.
- read_ack held high consumes one bit per cycle.
- frame_done and rx_ready rise on the edge that accepts the 32nd read_ack.
- rst_n asserted mid-operation:
  - Outputs clear immediately, asynchronously.
  - Partial frame and decoded bits are discarded.
  - The block restarts in LOAD.
- Simultaneous sym_valid/start/read_ack: only the input relevant to the current state acts.

## Configuration
- VITERBI_METRIC_OUT_EN defined:
  - uio_oe=8'hFF.
  - uio_out={1'b0, best final path metric[6:0]}, latched at start and held until the next start or reset.
- Undefined: uio_out=0, uio_oe=0, and no metric latch is built.

## Test plan
- Pattern 32'hB4B4B4B4 (bit0 first):
  - Encode from state 0 and feed 32 symbols with valid pulses.
  - Pulse start, wait until busy=0, then read with read_ack pulses.
  - Required: decoded=32'hB4B4B4B4 with 0 errors; frame_done=1 after the 32nd ack.
- All-zero input (32 symbols 2'b00):
  - Required: 32 zero bits out.
  - With VITERBI_METRIC_OUT_EN: uio_out=0.
- Single-error correction:
  - Take the B4B4B4B4 stream and flip sym[1] of symbol 10.
  - Required: decoded=32'hB4B4B4B4.
  - With VITERBI_METRIC_OUT_EN: best metric=1.
- start pulsed after only 20 symbols:
  - Required: busy stays 0 and rx_ready stays 1.
  - Feeding the remaining 12 symbols then pulsing start decodes correctly.
- Back-to-back frames:
  - Decode B4B4B4B4, then feed a second frame encoded from 32'h12345678, restarting the encoder at state 0.
  - Required: second output=32'h12345678; frame_done clears on the first new symbol.
- Reset mid-output:
  - Assert rst_n low after 10 bits have been read.
  - Required: uo_out=0 during reset, rx_ready=1 after release, and a fresh frame decodes correctly.
